// File: rtl/lcd_text_writer.sv
// HD44780-class character LCD writer: power-up wait, init, ROWS x COLS frame
// refresh from a per-frame text snapshot, and a host command channel.
module lcd_text_writer #(
   parameter int COLS         = 16,
   parameter int ROWS         = 2,
   parameter int EN_CYC       = 20,
   parameter int CMD_CYC      = 2500,
   parameter int CLR_CYC      = 85000,
   parameter int PWR_CYC      = 750000,
   parameter bit AUTO_REFRESH = 1'b1
) (
   input  logic                   iCLK_50,
   input  logic                   iRST_N,
   input  logic [ROWS*COLS*8-1:0] iText,
   input  logic                   iUpdate,
   input  logic                   iCmd_valid,
   input  logic [7:0]             iCmd,
   output logic                   oCmd_ready,
   output logic                   oLCD_EN,
   output logic                   oLCD_RS,
   output logic [7:0]             oLCD_D,
   output logic                   oBusy,
   output logic                   oFrameDone
);

   localparam int TW    = ROWS * COLS * 8;
   localparam int CMAX  = (PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC;
   localparam int CNT_W = $clog2(CMAX + 1);
   localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;

   localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_CYC - 1);
   localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_CYC - 1);
   localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_CYC - 1);
   localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYC - 1);
   localparam logic [CW-1:0]    COL_LAST = CW'(COLS - 1);
   localparam logic [1:0]       ROW_LAST = 2'(ROWS - 1);

   typedef enum logic [2:0] {S_PWR, S_INIT, S_IDLE, S_FRAME, S_CMD} state_t;
   typedef enum logic [1:0] {P_SETUP, P_STROBE, P_WAIT} phase_t;

   state_t           r_state;
   phase_t           r_phase;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_init_idx;
   logic [1:0]       r_row;
   logic [CW-1:0]    r_col;
   logic             r_addr;
   logic [TW-1:0]    r_snap;

   logic             w_clr;
   logic [CNT_W-1:0] w_wait_last;
   logic             w_byte_done;
   logic [TW-1:0]    w_snap_shift;

   function automatic logic [7:0] init_byte(input logic [1:0] i);
      case (i)
         2'd0:    init_byte = 8'h38;
         2'd1:    init_byte = 8'h0C;
         2'd2:    init_byte = 8'h01;
         default: init_byte = 8'h06;
      endcase
   endfunction

   function automatic logic [7:0] row_addr(input logic [1:0] r);
      case (r)
         2'd0:    row_addr = 8'h80;
         2'd1:    row_addr = 8'hC0;
         2'd2:    row_addr = 8'h80 | 8'(COLS);
         default: row_addr = 8'h80 | (8'h40 + 8'(COLS));
      endcase
   endfunction

   // RS/D are held for the whole byte, so the wait length follows the outputs.
   assign w_clr        = !oLCD_RS && (oLCD_D == 8'h01 || oLCD_D == 8'h02);
   assign w_wait_last  = w_clr ? CLR_LAST : CMD_LAST;
   assign w_byte_done  = (r_phase == P_WAIT) && (r_cnt == w_wait_last);
   assign w_snap_shift = r_snap << 8;

   assign oBusy      = (r_state != S_IDLE);
   assign oCmd_ready = (r_state == S_IDLE) && iCmd_valid;

   always_ff @(posedge iCLK_50 or negedge iRST_N) begin
      if (!iRST_N) begin
         r_state    <= S_PWR;
         r_phase    <= P_SETUP;
         r_cnt      <= '0;
         r_init_idx <= '0;
         r_row      <= '0;
         r_col      <= '0;
         r_addr     <= 1'b0;
         r_snap     <= '0;
         oLCD_EN    <= 1'b0;
         oLCD_RS    <= 1'b0;
         oLCD_D     <= 8'h00;
         oFrameDone <= 1'b0;
      end else begin
         oFrameDone <= 1'b0;
         case (r_state)
            S_PWR: begin
               if (r_cnt == PWR_LAST) begin
                  r_state    <= S_INIT;
                  r_init_idx <= 2'd0;
                  oLCD_D     <= init_byte(2'd0);
                  oLCD_RS    <= 1'b0;
                  r_phase    <= P_SETUP;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_IDLE: begin
               if (iCmd_valid) begin
                  r_state <= S_CMD;
                  oLCD_D  <= iCmd;
                  oLCD_RS <= 1'b0;
                  r_phase <= P_SETUP;
               end else if (iUpdate || AUTO_REFRESH) begin
                  r_state <= S_FRAME;
                  r_snap  <= iText;
                  r_row   <= 2'd0;
                  r_col   <= '0;
                  r_addr  <= 1'b1;
                  oLCD_D  <= row_addr(2'd0);
                  oLCD_RS <= 1'b0;
                  r_phase <= P_SETUP;
               end
            end
            default: begin
               case (r_phase)
                  P_SETUP: begin
                     oLCD_EN <= 1'b1;
                     r_phase <= P_STROBE;
                     r_cnt   <= '0;
                  end
                  P_STROBE: begin
                     if (r_cnt == EN_LAST) begin
                        oLCD_EN <= 1'b0;
                        r_phase <= P_WAIT;
                        r_cnt   <= '0;
                     end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                     end
                  end
                  default: begin
                     if (!w_byte_done) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                     end else if (r_state == S_INIT) begin
                        if (r_init_idx == 2'd3) begin
                           r_state <= S_IDLE;
                        end else begin
                           r_init_idx <= r_init_idx + 2'd1;
                           oLCD_D     <= init_byte(r_init_idx + 2'd1);
                           r_phase    <= P_SETUP;
                        end
                     end else if (r_state == S_CMD) begin
                        r_state <= S_IDLE;
                     end else if (r_addr) begin
                        // Current character always sits in the top byte of the snapshot.
                        r_addr  <= 1'b0;
                        r_col   <= '0;
                        oLCD_D  <= r_snap[TW-1 -: 8];
                        oLCD_RS <= 1'b1;
                        r_phase <= P_SETUP;
                     end else begin
                        r_snap <= w_snap_shift;
                        if (r_col != COL_LAST) begin
                           r_col   <= r_col + CW'(1);
                           oLCD_D  <= w_snap_shift[TW-1 -: 8];
                           oLCD_RS <= 1'b1;
                           r_phase <= P_SETUP;
                        end else if (r_row != ROW_LAST) begin
                           r_row   <= r_row + 2'd1;
                           r_addr  <= 1'b1;
                           oLCD_D  <= row_addr(r_row + 2'd1);
                           oLCD_RS <= 1'b0;
                           r_phase <= P_SETUP;
                        end else begin
                           r_state    <= S_IDLE;
                           oFrameDone <= 1'b1;
                        end
                     end
                  end
               endcase
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_text_writer.sv
// Directed bench for lcd_text_writer: a 2x16 on-demand instance and a 4x20
// auto-refresh instance, with byte capture on each EN rising edge.
module tb_lcd_text_writer;

   bit clk = 1'b0;
   always #5 clk = ~clk;

   logic         iRST_N;
   logic [255:0] iText1;
   logic [639:0] iText2;
   logic         iUpdate1, iCmd_valid1;
   logic [7:0]   iCmd1;
   logic         rdy1, en1, rs1, busy1, fd1o;
   logic [7:0]   d1;
   logic         rdy2, en2, rs2, busy2, fd2o;
   logic [7:0]   d2;

   lcd_text_writer #(.COLS(16), .ROWS(2), .EN_CYC(2), .CMD_CYC(4), .CLR_CYC(10),
                     .PWR_CYC(8), .AUTO_REFRESH(1'b0)) dut1 (
      .iCLK_50(clk), .iRST_N(iRST_N), .iText(iText1), .iUpdate(iUpdate1),
      .iCmd_valid(iCmd_valid1), .iCmd(iCmd1), .oCmd_ready(rdy1), .oLCD_EN(en1),
      .oLCD_RS(rs1), .oLCD_D(d1), .oBusy(busy1), .oFrameDone(fd1o));

   lcd_text_writer #(.COLS(20), .ROWS(4), .EN_CYC(2), .CMD_CYC(4), .CLR_CYC(10),
                     .PWR_CYC(8), .AUTO_REFRESH(1'b1)) dut2 (
      .iCLK_50(clk), .iRST_N(iRST_N), .iText(iText2), .iUpdate(1'b0),
      .iCmd_valid(1'b0), .iCmd(8'h00), .oCmd_ready(rdy2), .oLCD_EN(en2),
      .oLCD_RS(rs2), .oLCD_D(d2), .oBusy(busy2), .oFrameDone(fd2o));

   int checks = 0;
   int errors = 0;
   int cyc;

   logic [7:0] qd1[$], qd2[$];
   bit         qrs1[$], qrs2[$];
   int         qs1[$], qs2[$], qh1[$], fdq1[$], fdq2[$];
   bit         pen1 = 1'b0, pen2 = 1'b0;
   int         hc1 = 0, stab1 = 0, rdy_cnt1 = 0, rdy_bad1 = 0, rdy_cyc1 = 0;

   always @(posedge clk or negedge iRST_N)
      if (!iRST_N) cyc <= 0;
      else         cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!iRST_N) begin
         if (pen1) qh1.push_back(hc1);
         pen1 <= 1'b0;
         hc1  <= 0;
      end else begin
         pen1 <= en1;
         if (en1 && !pen1) begin
            qd1.push_back(d1); qrs1.push_back(rs1); qs1.push_back(cyc);
         end
         if (en1) hc1 <= (pen1 ? hc1 : 0) + 1;
         else if (pen1) begin qh1.push_back(hc1); hc1 <= 0; end
         if (en1 && pen1 && (d1 != qd1[$] || rs1 != qrs1[$])) stab1 <= stab1 + 1;
         if (fd1o) fdq1.push_back(cyc);
         if (rdy1) begin
            rdy_cnt1 <= rdy_cnt1 + 1;
            rdy_cyc1 <= cyc;
            if (busy1) rdy_bad1 <= rdy_bad1 + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (!iRST_N) pen2 <= 1'b0;
      else begin
         pen2 <= en2;
         if (en2 && !pen2) begin
            qd2.push_back(d2); qrs2.push_back(rs2); qs2.push_back(cyc);
         end
         if (fd2o) fdq2.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk); #1;
   endtask

   task automatic wait_q1(input int n, input string tag);
      int k = 0;
      while (qd1.size() < n && k < 4000) begin tick(); k++; end
      chk(tag, 32'(qd1.size() >= n), 32'd1);
   endtask

   task automatic wait_q2(input int n, input string tag);
      int k = 0;
      while (qd2.size() < n && k < 4000) begin tick(); k++; end
      chk(tag, 32'(qd2.size() >= n), 32'd1);
   endtask

   task automatic wait_fd1(input int n, input string tag);
      int k = 0;
      while (fdq1.size() < n && k < 4000) begin tick(); k++; end
      chk(tag, 32'(fdq1.size() >= n), 32'd1);
   endtask

   task automatic pulse_update(output int u);
      u = cyc;
      iUpdate1 = 1'b1;
      tick();
      iUpdate1 = 1'b0;
   endtask

   task automatic check_init(input int b);
      logic [7:0] exp_b [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
      wait_q1(b + 4, "init_timeout");
      repeat (4) tick();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("init_byte%0d", i), {23'd0, qrs1[b+i], qd1[b+i]}, {24'd0, exp_b[i]});
         chk($sformatf("init_en_hi%0d", i), qh1[b+i], 2);
      end
      chk("init_first_en", qs1[b], 9);
      chk("init_gap0", qs1[b+1] - qs1[b], 7);
      chk("init_gap1", qs1[b+2] - qs1[b+1], 7);
      chk("init_gap_clr", qs1[b+3] - qs1[b+2], 13);
   endtask

   task automatic check_frame(input int b, input logic [255:0] t);
      chk("frame_addr0", {23'd0, qrs1[b], qd1[b]}, 32'h080);
      chk("frame_addr1", {23'd0, qrs1[b+17], qd1[b+17]}, 32'h0C0);
      for (int c = 0; c < 16; c++) begin
         chk($sformatf("row0_col%0d", c), {23'd0, qrs1[b+1+c], qd1[b+1+c]},
             {23'd0, 1'b1, t[255-8*c -: 8]});
         chk($sformatf("row1_col%0d", c), {23'd0, qrs1[b+18+c], qd1[b+18+c]},
             {23'd0, 1'b1, t[255-8*(16+c) -: 8]});
      end
   endtask

   initial begin
      logic [255:0] txt_a, txt_b;
      int u, b, k;
      txt_a = "HELLO WORLD     0123456789ABCDEF";
      txt_b = "abcdefghijklmnopqrstuvwxyz012345";
      iRST_N = 1'b0; iText1 = txt_a; iUpdate1 = 1'b0; iCmd_valid1 = 1'b0; iCmd1 = 8'h00;
      for (int i = 0; i < 80; i++) iText2[639-8*i -: 8] = 8'h41 + 8'(i % 26);

      // reset state
      repeat (3) tick();
      chk("rst_en", en1, 0); chk("rst_rs", rs1, 0); chk("rst_d", d1, 0);
      chk("rst_busy", busy1, 1); chk("rst_ready", rdy1, 0); chk("rst_fd", fd1o, 0);

      // power-up wait and init
      iRST_N = 1'b1;
      check_init(0);
      repeat (10) tick();
      chk("idle_busy", busy1, 0);
      chk("idle_no_frame", qd1.size(), 4);

      // one 2x16 frame on request
      pulse_update(u);
      wait_q1(38, "frame1_timeout");
      chk("frame1_latency", qs1[4], u + 2);
      check_frame(4, txt_a);
      wait_fd1(1, "fd1_timeout");
      chk("frame1_done_cyc", fdq1[0], qs1[37] + 6);
      tick();
      chk("frame1_idle", busy1, 0);
      chk("frame1_one_pulse", fdq1.size(), 1);

      // snapshot: text change mid-frame shows up only in the next frame
      pulse_update(u);
      wait_q1(42, "snap_timeout");
      iText1 = txt_b;
      wait_fd1(2, "fd2_timeout");
      check_frame(38, txt_a);
      tick();
      pulse_update(u);
      wait_fd1(3, "fd3_timeout");
      check_frame(72, txt_b);

      // command during a frame waits for the frame, then wins over an update
      pulse_update(u);
      wait_q1(111, "cmd_frame_timeout");
      iCmd1 = 8'h01; iCmd_valid1 = 1'b1; iUpdate1 = 1'b1;
      k = 0;
      while (rdy_cnt1 == 0 && k < 2000) begin tick(); k++; end
      @(posedge clk); #1;
      iCmd_valid1 = 1'b0;
      chk("cmd_ready_seen", rdy_cnt1, 1);
      chk("cmd_no_ready_busy", rdy_bad1, 0);
      chk("cmd_frames_before", fdq1.size(), 4);
      chk("cmd_after_done", 32'(rdy_cyc1 >= fdq1[3]), 1);
      wait_q1(142, "cmd_next_timeout");
      iUpdate1 = 1'b0;
      chk("cmd_byte", {23'd0, qrs1[140], qd1[140]}, 32'h001);
      chk("cmd_start", qs1[140], rdy_cyc1 + 2);
      chk("cmd_clr_gap", qs1[141] - qs1[140], 14);
      chk("cmd_then_frame", {23'd0, qrs1[141], qd1[141]}, 32'h080);
      wait_fd1(5, "fd5_timeout");
      chk("stable_rs_d", stab1, 0);

      // 4x20 auto-refresh instance
      wait_q2(89, "dut2_timeout");
      chk("d2_addr0", {23'd0, qrs2[4], qd2[4]}, 32'h080);
      chk("d2_addr1", {23'd0, qrs2[25], qd2[25]}, 32'h0C0);
      chk("d2_addr2", {23'd0, qrs2[46], qd2[46]}, 32'h094);
      chk("d2_addr3", {23'd0, qrs2[67], qd2[67]}, 32'h0D4);
      chk("d2_char00", {23'd0, qrs2[5], qd2[5]}, 32'h141);
      chk("d2_char10", {23'd0, qrs2[26], qd2[26]}, 32'h155);
      chk("d2_next_frame", {23'd0, qrs2[88], qd2[88]}, 32'h080);
      chk("d2_done_cyc", fdq2[0], qs2[87] + 6);
      chk("d2_idle_gap", qs2[88], fdq2[0] + 2);

      // reset during a strobe
      pulse_update(u);
      k = 0;
      while (!en1 && k < 100) begin tick(); k++; end
      chk("strobe_seen", en1, 1);
      iRST_N = 1'b0;
      #1;
      chk("mid_rst_en", en1, 0); chk("mid_rst_rs", rs1, 0); chk("mid_rst_d", d1, 0);
      chk("mid_rst_busy", busy1, 1); chk("mid_rst_ready", rdy1, 0);
      repeat (2) tick();
      b = qd1.size();
      iRST_N = 1'b1;
      check_init(b);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
